// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NREQ producers, the write arbiter and the
// FIFO write port. The master side drives requests and the FIFO full flag;
// the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic                   fifo_full;
    logic                   fifo_we;
    logic [DATA_W-1:0]      fifo_din;
    logic [IDX_W-1:0]       owner_idx;
    logic                   busy;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_we, fifo_din, owner_idx, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_we, fifo_din, owner_idx, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts for at most MAX_BURST accepted words; a full FIFO stalls the
// owner without ending its burst. Handoffs to the next requester happen
// without an idle cycle when possible.
// Optional build macro FIFO_ARB_STATS_EN adds a saturating 16-bit count of
// cycles in which the owner was stalled by a full FIFO.
//
// state | meaning
// IDLE  | no owner, gnt all zero, waiting for a request and room in the FIFO
// OWN   | one requester holds the write port for its current burst
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    fifo_wr_arbiter_if.slave        bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state;
    logic [NREQ-1:0]  gnt_r;
    logic [IDX_W-1:0] owner_r;
    logic             busy_r;
    logic [CNT_W-1:0] burst_cnt;
    logic [IDX_W-1:0] last_winner;

    logic [NREQ-1:0]  ack;
    logic             we;
    logic             owner_req;
    logic             exhaust;
    logic             rel;
    logic [NREQ-1:0]  cand;
    int               start;
    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [NREQ-1:0]  win_onehot;
    logic [DATA_W-1:0] din;

    // Handshake: the owner's word is consumed on any edge where it requests
    // and the FIFO has room.
    always_comb begin
        ack       = gnt_r & bus.req & {NREQ{~bus.fifo_full}};
        we        = |ack;
        owner_req = |(gnt_r & bus.req);
        exhaust   = we && (burst_cnt == CNT_W'(MAX_BURST - 1));
        rel       = !owner_req || exhaust;
    end

    // Round-robin search from last_winner+1; an owner that used up its burst
    // is masked out so the others get a turn before it is regranted.
    always_comb begin
        cand     = exhaust ? (bus.req & ~gnt_r) : bus.req;
        start    = (int'(last_winner) >= NREQ - 1) ? 0 : int'(last_winner) + 1;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                if (i >= start) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
        win_found  = lo_found;
        win_idx    = hi_found ? hi_idx : lo_idx;
        win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end

    // Write data mux on the registered owner, forced to zero while idle.
    always_comb begin
        din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (busy_r && (owner_r == IDX_W'(i))) begin
                din = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Grant FSM: grant, count the burst, release and hand off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt_r       <= '0;
            owner_r     <= '0;
            busy_r      <= 1'b0;
            burst_cnt   <= '0;
            last_winner <= IDX_W'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found && !bus.fifo_full) begin
                        state       <= OWN;
                        gnt_r       <= win_onehot;
                        owner_r     <= win_idx;
                        last_winner <= win_idx;
                        busy_r      <= 1'b1;
                        burst_cnt   <= '0;
                    end
                end
                OWN: begin
                    if (rel) begin
                        if (win_found && !bus.fifo_full) begin
                            gnt_r       <= win_onehot;
                            owner_r     <= win_idx;
                            last_winner <= win_idx;
                            burst_cnt   <= '0;
                        end else begin
                            state     <= IDLE;
                            gnt_r     <= '0;
                            owner_r   <= '0;
                            busy_r    <= 1'b0;
                            burst_cnt <= '0;
                        end
                    end else if (we) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Saturating count of owner cycles blocked by a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (busy_r && owner_req && bus.fifo_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    assign bus.gnt       = gnt_r;
    assign bus.ack       = ack;
    assign bus.fifo_we   = we;
    assign bus.fifo_din  = din;
    assign bus.owner_idx = owner_r;
    assign bus.busy      = busy_r;

endmodule
